// File: rtl/adpt_seg_pkg.sv
// Shared constants and helpers for the adpt_seg eight-digit hex display scanner.
package adpt_seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  // Active-low pattern with every segment (and dp) dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; dp stays dark.
  localparam logic [7:0] GLYPH_0 = 8'hC0;
  localparam logic [7:0] GLYPH_1 = 8'hF9;
  localparam logic [7:0] GLYPH_2 = 8'hA4;
  localparam logic [7:0] GLYPH_3 = 8'hB0;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h92;
  localparam logic [7:0] GLYPH_6 = 8'h82;
  localparam logic [7:0] GLYPH_7 = 8'hF8;
  localparam logic [7:0] GLYPH_8 = 8'h80;
  localparam logic [7:0] GLYPH_9 = 8'h90;
  localparam logic [7:0] GLYPH_A = 8'h88;
  localparam logic [7:0] GLYPH_B = 8'h83;
  localparam logic [7:0] GLYPH_C = 8'hC6;
  localparam logic [7:0] GLYPH_D = 8'hA1;
  localparam logic [7:0] GLYPH_E = 8'h86;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  // Index of the most significant nonzero nibble; 0 when the whole value is 0,
  // so digit 0 is always treated as significant.
  function automatic logic [IDX_W-1:0] top_nz(input logic [4*NUM_DIGITS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] != 4'h0) r = IDX_W'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/adpt_seg_hex7.sv
// Nibble to active-low seven-segment glyph decoder (purely combinational).
module hex7
  import adpt_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);

  // Table lookup of the hex glyph for one nibble.
  always_comb begin
    seg_o = SEG_OFF;
    case (nib_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/adpt_seg.sv
// Eight-digit multiplexed hex display driver. A new value is staged in a
// pending register and only promoted to the display register at a frame
// boundary, so each scan frame shows one consistent value.
module adpt_seg
  import adpt_seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] val,
  input  logic        ld,
  input  logic        blank_lz,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  localparam int             PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;

  logic             tick;
  logic             frame_end;
  logic [3:0]       cur_nib;
  logic [7:0]       cur_glyph;
  logic [IDX_W-1:0] top_idx;
  logic             blank_now;

  assign tick      = (presc_q == PRE_MAX);
  assign frame_end = tick && (idx_q == IDX_LAST);
  assign cur_nib   = disp_q[{idx_q, 2'b00} +: 4];
  assign top_idx   = top_nz(disp_q);
  // Leading-zero blanking follows blank_lz live; digit 0 can never exceed top_idx.
  assign blank_now = blank_lz && (idx_q > top_idx);

  hex7 u_hex7 (
    .nib_i (cur_nib),
    .seg_o (cur_glyph)
  );

  // Next-state: scan timing, pending/display handoff, and the registered digit drive.
  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    idx_d      = tick ? idx_q + IDX_W'(1) : idx_q;
    disp_d     = disp_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;

    // Promotion uses the old pending value; a same-cycle ld re-arms pend below.
    if (frame_end && pend_q) begin
      disp_d = pend_val_q;
      pend_d = 1'b0;
    end
    if (ld) begin
      pend_val_d = val;
      pend_d     = 1'b1;
    end

    seg_d = blank_now ? SEG_OFF : cur_glyph;
    an_d  = blank_now ? SEG_OFF : ~(8'(1) << idx_q);
  end

  // State registers; clr clears everything at once, dropping any staged value.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_q    <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= SEG_OFF;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_adpt_seg.sv
// Scoreboard bench for adpt_seg with SCAN_DIV=4: expected digit slots are queued
// by the stimulus process and a monitor checks every cycle of every slot.
module tb_adpt_seg;

  localparam int SD = 4;

  typedef struct {
    int         slot;
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        ld = 1'b0;
  logic        blank_lz = 1'b0;
  logic [31:0] val = 32'h0;
  logic [7:0]  seg;
  logic [7:0]  an;

  int   ecnt  = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  adpt_seg #(.SCAN_DIV(SD)) dut (
    .clk      (clk),
    .clr      (clr),
    .val      (val),
    .ld       (ld),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  // Rising edges since clr was released.
  always @(posedge clk) begin
    if (clr) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", name, act, req);
    end
  endtask

  // g holds eight active-low glyph bytes, digit 7 in the top byte; FF means blanked.
  task automatic push_frame(input int f, input logic [63:0] g, input int nslots);
    exp_t e;
    logic [7:0] b;
    for (int k = 0; k < nslots; k++) begin
      b      = g[8*k +: 8];
      e.slot = f * 8 + k;
      e.seg  = b;
      e.an   = (b == 8'hFF) ? 8'hFF : ~(8'(1) << k);
      exp_q.push_back(e);
    end
  endtask

  // Return at the falling edge following rising edge n.
  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (ecnt < n) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        $display("FAIL wait_edge: edge %0d never reached (at %0d)", n, ecnt);
        $fatal(1, "bench timeout");
      end
    end
  endtask

  // Drive ld so it is sampled on rising edge n.
  task automatic pulse_ld(input int n, input logic [31:0] v);
    wait_edge(n - 1);
    ld  = 1'b1;
    val = v;
    @(negedge clk);
    ld  = 1'b0;
  endtask

  // Monitor: sample 1 time unit after each falling edge.
  initial begin
    int   slot;
    int   pos;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (clr) begin
        chk("clr_seg", seg, 8'hFF);
        chk("clr_an", an, 8'hFF);
      end else if (ecnt >= 1) begin
        n_vec++;
        if (!((an == 8'hFF) || ($countones(~an) == 1))) begin
          n_bad++;
          $display("FAIL an_onehot: got %02h want one-hot-low or FF (edge %0d)", an, ecnt);
        end
        slot = (ecnt - 1) / SD;
        pos  = (ecnt - 1) % SD;
        while (exp_q.size() > 0 && exp_q[0].slot < slot) begin
          n_vec++;
          n_bad++;
          $display("FAIL slot_missed: got nothing for slot %0d want an %02h seg %02h",
                   exp_q[0].slot, exp_q[0].an, exp_q[0].seg);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].slot == slot) begin
          e = exp_q[0];
          chk($sformatf("slot%0d_c%0d_an", slot, pos), an, e.an);
          chk($sformatf("slot%0d_c%0d_seg", slot, pos), seg, e.seg);
          if (pos == SD - 1) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus.
  initial begin
    repeat (3) @(negedge clk);

    // Frame 0: reset value; frame 1: 12345678.
    push_frame(0, 64'hC0C0C0C0C0C0C0C0, 8);
    push_frame(1, 64'hF9A4B0999282F880, 8);
    // Frame 2: BEEF only (AAAA0000 overwritten while pending).
    push_frame(2, 64'hC0C0C0C08386868E, 8);
    // Frame 3: CAFE; frame 4: value loaded on the boundary edge.
    push_frame(3, 64'hC0C0C0C0C6888E86, 8);
    push_frame(4, 64'h80F8829299B0A4F9, 8);
    // Frame 5: 00000A30 with blanking; frame 6: zero, first four slots before clr.
    push_frame(5, 64'hFFFFFFFFFF88B0C0, 8);
    push_frame(6, 64'hFFFFFFFFFFFFFFC0, 4);

    clr = 1'b0;
    pulse_ld(5,   32'h12345678);
    pulse_ld(40,  32'hAAAA0000);
    pulse_ld(50,  32'h0000BEEF);
    pulse_ld(70,  32'h0000CAFE);
    pulse_ld(96,  32'h87654321);
    pulse_ld(140, 32'h00000A30);
    wait_edge(160);
    blank_lz = 1'b1;
    pulse_ld(170, 32'h00000000);
    pulse_ld(200, 32'h0000DEAD);

    // Mid-frame clear with DEAD still pending.
    wait_edge(210);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL epoch1_leftover: got %0d unchecked slots want 0", exp_q.size());
    end
    exp_q.delete();
    blank_lz = 1'b0;
    push_frame(0, 64'hC0C0C0C0C0C0C0C0, 8);
    push_frame(1, 64'hC0C0C0C0C0C0C0C0, 8);
    clr = 1'b0;
    wait_edge(66);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL epoch2_leftover: got %0d unchecked slots want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/adpt_seg.md
ADPT_SEG -- requirements
Module: adpt_seg

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each digit stays lit; legal range 2..2^20.
REQ-002 clk  input  1  board system clock; all state updates on its rising edge.
REQ-003 clr  input  1  reset; asynchronous, active-high.
REQ-004 val  input  32  value to display, eight hex nibbles; val[3:0] is the rightmost digit.
REQ-005 ld  input  1  load strobe; val is sampled on a rising clk edge while ld=1.
REQ-006 blank_lz  input  1  1 = blank leading zero digits.
REQ-007 seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-008 an  output  8  digit anodes, active-low, one-hot when lit; an[0] is the rightmost digit.

Function
REQ-009 Prescaler counts 0..SCAN_DIV-1 then wraps to 0; wrap cycle = tick.
REQ-010 Digit index idx (3 bits) increments on tick, wrapping 7->0; the idx 7->0 wrap on tick = frame boundary.
REQ-011 ld=1 captures val into the pending register and sets the pend flag; with repeated ld, the latest value wins.
REQ-012 At a frame boundary with pend=1: pending register -> display register, pend cleared; display register otherwise unchanged.
REQ-013 ld=1 in the same cycle as a frame-boundary transfer: the old pending value transfers; the new val is captured and pend stays 1.
REQ-014 Display register is never updated mid-frame; a frame shows one consistent value.
REQ-015 seg and an are registered: they reflect idx one cycle after idx changes.
REQ-016 Lit digit: an = ~(1<<idx); seg = hex glyph of display nibble idx, active-low; dp always 1 (off).
REQ-017 Glyph table covers 0-9, A, b, C, d, E, F (standard hex 7-segment shapes, e.g. 0 -> 8'hC0, 8 -> 8'h80, F -> 8'h8E).
REQ-018 blank_lz=1: digit k with k > index of highest nonzero nibble is blanked (an=8'hFF, seg=8'hFF).
REQ-019 Digit 0 is never blanked; display value 0 with blank_lz=1 shows a single "0".
REQ-020 blank_lz is sampled combinationally each cycle, not latched per frame.

Reset
REQ-021 clr=1 forces immediately: prescaler=0, idx=0, display register=0, pending register=0, pend=0, seg=8'hFF, an=8'hFF.
REQ-022 First rising edge after clr falls: an=8'hFE, seg=8'hC0 (digit 0 shows "0").
REQ-023 clr asserted mid-frame discards any pending value; no partial transfer.

Structure
REQ-024 Shared package holds: NUM_DIGITS=8, SEG_OFF=8'hFF, glyph constants for 0-F.
REQ-025 One combinational sub-module, hex7 (4-bit nibble -> 8-bit active-low glyph), is instantiated once on the selected nibble.
REQ-026 No other sub-modules; target 120-250 RTL lines.

Verification (bench uses SCAN_DIV=4)
REQ-027 Reset, then val=32'h12345678 with one ld pulse -> digits show 0 until the first frame boundary; then over one frame an sweeps FE,FD,...,7F with seg = glyphs 8,7,6,5,4,3,2,1.
REQ-028 ld pulses with 32'hAAAA0000 then 32'h0000BEEF within one frame -> next frame shows only BEEF; AAAA0000 never appears.
REQ-029 blank_lz=1, val=32'h00000A30 -> digits 0-2 lit (0,3,A); digits 3-7 have an=FF, seg=FF; val=0 -> only digit 0 lit, showing "0".
REQ-030 ld asserted exactly on the frame-boundary cycle -> the old pending value is displayed this frame and the new value next frame.
REQ-031 clr pulsed mid-frame with pend=1 -> outputs FF/FF while clr=1; afterwards digit 0 shows "0" and the discarded value never appears.
REQ-032 Check each digit is lit for exactly SCAN_DIV cycles and that an is one-hot-low or all-ones on every cycle.
